// File: rtl/program_counter_ras_if.sv
// Fetch-control bundle between decode/branch resolution (master) and the PC (slave).
// misalign exists only when PC_MISALIGN_TRAP_EN is defined.
`default_nettype none

interface program_counter_ras_if #(
  parameter int WIDTH = 32,
  parameter int OFF_W = 16
);
  logic             en;
  logic             br_taken;
  logic [OFF_W-1:0] br_off;
  logic             jmp;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misalign;
`endif

  modport master (
    output en, br_taken, br_off, jmp, call, ret, jmp_tgt,
`ifdef PC_MISALIGN_TRAP_EN
    input  misalign,
`endif
    input  pc, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  en, br_taken, br_off, jmp, call, ret, jmp_tgt,
`ifdef PC_MISALIGN_TRAP_EN
    output misalign,
`endif
    output pc, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

`default_nettype wire

// File: rtl/program_counter_ras.sv
// ============================================================================
// Module   : program_counter_ras
// Purpose  : fetch-stage PC with branch/jump and a circular return-address stack.
//            Optional alignment trap enabled by macro PC_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter_ras #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter int               OFF_W     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  program_counter_ras_if.slave bus
);

  localparam int                 c_PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                 c_CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0]   c_STEP     = WIDTH'(STEP);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(RAS_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RAS_DEPTH - 1);

  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_stack [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_unf;

  logic [WIDTH-1:0]   w_seq;
  logic [WIDTH-1:0]   w_br;
  logic [WIDTH-1:0]   w_top;
  logic [c_PTR_W-1:0] w_top_ptr;
  logic [c_PTR_W-1:0] w_ptr_inc;
  logic               w_empty;
  logic               w_full;
  logic [WIDTH-1:0]   w_tgt;
  logic               w_load;
  logic               w_push;
  logic               w_pop;
  logic               w_unf;
  logic [WIDTH-1:0]   w_pc_next;

  assign w_seq     = r_pc + c_STEP;
  assign w_br      = r_pc + {{(WIDTH-OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL_CNT);
  // write pointer names the next free slot; the top of stack sits just below it
  assign w_top_ptr = (r_wr_ptr == '0) ? c_LAST_PTR : r_wr_ptr - 1'b1;
  assign w_ptr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_top     = r_stack[w_top_ptr];

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [WIDTH-1:0] c_ALIGN_MASK = WIDTH'(STEP - 1);
  logic w_mis;
  logic r_mis;
`endif

  always_comb begin
    w_tgt  = w_seq;
    w_load = 1'b0;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_unf  = 1'b0;
    if (bus.ret) begin
      if (w_empty) begin
        w_unf = 1'b1;
      end else begin
        w_pop  = 1'b1;
        w_tgt  = w_top;
        w_load = 1'b1;
      end
    end else if (bus.call) begin
      w_push = 1'b1;
      w_tgt  = bus.jmp_tgt;
      w_load = 1'b1;
    end else if (bus.jmp) begin
      w_tgt  = bus.jmp_tgt;
      w_load = 1'b1;
    end else if (bus.br_taken) begin
      w_tgt  = w_br;
      w_load = 1'b1;
    end
`ifdef PC_MISALIGN_TRAP_EN
    // a rejected ret still pops; a rejected call must not push
    w_mis = 1'b0;
    if (w_load && ((w_tgt & c_ALIGN_MASK) != '0)) begin
      w_mis  = 1'b1;
      w_load = 1'b0;
      w_push = 1'b0;
    end
`endif
    w_pc_next = w_load ? w_tgt : w_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (bus.en) begin
      r_pc  <= w_pc_next;
      r_ovf <= w_push && w_full;
      r_unf <= w_unf;
      if (w_push) begin
        r_wr_ptr <= w_ptr_inc;
        if (!w_full) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_wr_ptr <= w_top_ptr;
        r_count  <= r_count - 1'b1;
      end
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end
  end

  // storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (bus.en && w_push) r_stack[r_wr_ptr] <= w_seq;
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_mis <= 1'b0;
    else if (bus.en) r_mis <= w_mis;
    else             r_mis <= 1'b0;
  end
  assign bus.misalign = r_mis;
`endif

  assign bus.pc        = r_pc;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = w_full;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_program_counter_ras.sv
// Vector-table bench for program_counter_ras; expected values queued at drive time, popped after the edge.
`default_nettype none

module tb_program_counter_ras;

  localparam int WIDTH = 32;
  localparam int OFF_W = 16;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        en, br, jmp, call, ret;
    logic [15:0] off;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        empty, full, ovf, unf, mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [$];
  vec_t sb  [$];

  always #5 clk = ~clk;

  program_counter_ras_if #(.WIDTH(WIDTH), .OFF_W(OFF_W)) bus ();

  program_counter_ras #(
    .WIDTH(WIDTH), .STEP(4), .OFF_W(OFF_W), .RAS_DEPTH(4), .RESET_PC('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic vec_t mk(logic en, logic br, logic [15:0] off, logic jmp, logic call,
                              logic ret, logic [31:0] tgt, logic [31:0] pc, logic empty,
                              logic full, logic ovf, logic unf, logic mis);
    vec_t v;
    v.en = en; v.br = br; v.off = off; v.jmp = jmp; v.call = call; v.ret = ret; v.tgt = tgt;
    v.pc = pc; v.empty = empty; v.full = full; v.ovf = ovf; v.unf = unf; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, n_vec, act, exp);
    end
  endtask

  task automatic check_outputs(vec_t e);
    n_vec++;
    chk("pc", bus.pc, e.pc);
    chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
    chk("ras_full", 32'(bus.ras_full), 32'(e.full));
    chk("ras_ovf", 32'(bus.ras_ovf), 32'(e.ovf));
    chk("ras_unf", 32'(bus.ras_unf), 32'(e.unf));
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign", 32'(bus.misalign), 32'(e.mis));
`endif
  endtask

  task automatic drive_idle();
    bus.en = 1'b0; bus.br_taken = 1'b0; bus.br_off = '0; bus.jmp = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.jmp_tgt = '0;
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    bus.en = v.en; bus.br_taken = v.br; bus.br_off = v.off; bus.jmp = v.jmp;
    bus.call = v.call; bus.ret = v.ret; bus.jmp_tgt = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: queue empty at vector %0d, expected 1 entry", n_vec);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 200000 exceeded, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    // reset state while rst_n held low
    repeat (2) @(posedge clk);
    #1;
    check_outputs(mk(0,0,0,0,0,0,0, 32'h0, 1,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;

    // three increments, a call, then an asynchronous reset mid-cycle
    apply(mk(1,0,0,0,0,0,0, 32'h4, 1,0,0,0,0));
    apply(mk(1,0,0,0,0,0,0, 32'h8, 1,0,0,0,0));
    apply(mk(1,0,0,0,0,0,0, 32'hC, 1,0,0,0,0));
    apply(mk(1,0,0,0,1,0,32'h20, 32'h20, 0,0,0,0,0));
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(mk(0,0,0,0,0,0,0, 32'h0, 1,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1,0,0,0,0,0,0, 32'h4, 1,0,0,0,0));
    apply(mk(1,0,0,0,0,0,0, 32'h8, 1,0,0,0,0));

    // stall and wrap
    tbl.push_back(mk(1,0,0,1,0,0,32'hFFFF_FFF8, 32'hFFFF_FFF8, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,             32'hFFFF_FFFC, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,             32'h0,         1,0,0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,16'h0010,0,0,0,0,    32'h0,         1,0,0,0,0));
    // branches and priority
    tbl.push_back(mk(1,0,0,1,0,0,32'h100,       32'h100,       1,0,0,0,0));
    tbl.push_back(mk(1,1,16'hFFF8,0,0,0,0,      32'hF8,        1,0,0,0,0));
    tbl.push_back(mk(1,1,16'h7FFC,0,0,0,0,      32'h80F4,      1,0,0,0,0));
    tbl.push_back(mk(1,1,16'h0010,1,0,0,32'h400,32'h400,       1,0,0,0,0));
    // call / return, and call+ret together on an empty stack
    tbl.push_back(mk(1,0,0,1,0,0,32'h40,        32'h40,        1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h200,       32'h200,       0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h44,        1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,1,32'h300,       32'h48,        1,0,0,1,0));
    // overflow then underflow
    tbl.push_back(mk(1,0,0,1,0,0,32'h0,         32'h0,         1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h10,        32'h10,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h20,        32'h20,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h30,        32'h30,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h40,        32'h40,        0,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h50,        32'h50,        0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h44,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h34,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h24,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h14,        1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h18,        1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,             32'h18,        1,0,0,0,0));
    // stall with a pending ret must not pop
    tbl.push_back(mk(1,0,0,0,1,0,32'h100,       32'h100,       0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,             32'h100,       0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h1C,        1,0,0,0,0));
    // pushed return address wraps
    tbl.push_back(mk(1,0,0,1,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,32'h300,       32'h300,       0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,             32'h0,         1,0,0,0,0));
    // misaligned jump target
    tbl.push_back(mk(1,0,0,1,0,0,32'h80,        32'h80,        1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,32'h102, MIS ? 32'h84 : 32'h102, 1,0,0,0,MIS));
    tbl.push_back(mk(1,0,0,0,0,0,0,       MIS ? 32'h88 : 32'h106, 1,0,0,0,0));
    // misaligned call: rejected without a push when trapping
    tbl.push_back(mk(1,0,0,0,1,0,32'h202, MIS ? 32'h8C : 32'h202, MIS,0,0,0,MIS));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
